// File: rtl/util_axis_uart_sync.sv
`default_nettype none
// ============================================================================
// Module      : util_axis_uart_sync
// Description : AXI-Stream <-> UART bridge. Bytes accepted on s_axis are
//               serialised on tx; frames received on rx are presented on
//               m_axis. Baud timing is an integer division of aclk.
//               Optional: define UTIL_AXIS_UART_RX_SYNC_EN to pass rx
//               through a 2-flop synchroniser (adds 2 cycles of rx latency).
// Ports       : aclk, arst (sync, active high)
//               s_axis_tdata/tvalid/tready : bytes to transmit
//               m_axis_tdata/tvalid/tready : received bytes
//               tx (serial out, idle high), rx (serial in, idle high)
// Revision    : 1.0 - initial release
// ============================================================================
module util_axis_uart_sync #(
    parameter int baud_clock_speed = 2000000,
    parameter int baud_rate        = 115200,
    parameter int parity_ena       = 0,
    parameter int parity_type      = 0,
    parameter int stop_bits        = 1,
    parameter int data_bits        = 8,
    parameter int rx_delay         = 0,
    parameter int tx_delay         = 0
) (
    input  logic                 aclk,
    input  logic                 arst,
    input  logic [data_bits-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [data_bits-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 tx,
    input  logic                 rx
);

    localparam int c_DIV   = baud_clock_speed / baud_rate;
    localparam int c_CNT_W = $clog2(c_DIV + rx_delay + tx_delay + 1);

    localparam logic [c_CNT_W-1:0] c_BIT_LAST      = c_CNT_W'(c_DIV - 1);
    // Edge is seen one cycle after rx falls, so the start sample lands at
    // DIV/2-1+rx_delay cycles after the detecting edge.
    localparam logic [c_CNT_W-1:0] c_RX_START_LAST = c_CNT_W'(c_DIV / 2 - 2 + rx_delay);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST      = c_CNT_W'((tx_delay > 0) ? tx_delay - 1 : 0);
    localparam logic [3:0]         c_DATA_LAST     = 4'(data_bits - 1);
    localparam logic [3:0]         c_STOP_LAST     = 4'(stop_bits - 1);
    localparam logic               c_PAR_EN        = (parity_ena != 0);
    localparam logic               c_PAR_ODD       = (parity_type != 0);

    localparam logic [2:0] c_TX_IDLE   = 3'd0;
    localparam logic [2:0] c_TX_START  = 3'd1;
    localparam logic [2:0] c_TX_DATA   = 3'd2;
    localparam logic [2:0] c_TX_PARITY = 3'd3;
    localparam logic [2:0] c_TX_STOP   = 3'd4;
    localparam logic [2:0] c_TX_GAP    = 3'd5;

    localparam logic [2:0] c_RX_IDLE   = 3'd0;
    localparam logic [2:0] c_RX_START  = 3'd1;
    localparam logic [2:0] c_RX_DATA   = 3'd2;
    localparam logic [2:0] c_RX_PARITY = 3'd3;
    localparam logic [2:0] c_RX_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [2:0]           r_tx_state;
    logic [c_CNT_W-1:0]   r_tx_cnt;
    logic [3:0]           r_tx_bit;
    logic [data_bits-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 r_tx;
    logic                 r_s_tready;
    logic                 w_tx_bit_end;

    assign w_tx_bit_end  = (r_tx_cnt == c_BIT_LAST);
    assign tx            = r_tx;
    assign s_axis_tready = r_s_tready;

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_tx_state <= c_TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
            r_s_tready <= 1'b0;
        end else begin
            case (r_tx_state)
                c_TX_IDLE: begin
                    if (r_s_tready && s_axis_tvalid) begin
                        r_tx_shift <= s_axis_tdata;
                        r_tx_par   <= (^s_axis_tdata) ^ c_PAR_ODD;
                        r_s_tready <= 1'b0;
                        r_tx       <= 1'b0;
                        r_tx_cnt   <= '0;
                        r_tx_state <= c_TX_START;
                    end else begin
                        r_s_tready <= 1'b1;
                    end
                end
                c_TX_START: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_state <= c_TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                c_TX_DATA: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == c_DATA_LAST) begin
                            r_tx_bit <= '0;
                            if (c_PAR_EN) begin
                                r_tx       <= r_tx_par;
                                r_tx_state <= c_TX_PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_tx_state <= c_TX_STOP;
                            end
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                c_TX_PARITY: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_tx       <= 1'b1;
                        r_tx_state <= c_TX_STOP;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                c_TX_STOP: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == c_STOP_LAST) begin
                            r_tx_bit <= '0;
                            // tready rises on the edge that ends the frame
                            // (or the gap) so the next accept follows 1 cycle later.
                            if (tx_delay > 0) begin
                                r_tx_state <= c_TX_GAP;
                            end else begin
                                r_s_tready <= 1'b1;
                                r_tx_state <= c_TX_IDLE;
                            end
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                c_TX_GAP: begin
                    if (r_tx_cnt == c_GAP_LAST) begin
                        r_tx_cnt   <= '0;
                        r_s_tready <= 1'b1;
                        r_tx_state <= c_TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx_state <= c_TX_IDLE;
                    r_tx       <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver input conditioning
    // ------------------------------------------------------------------
    logic w_rx;

`ifdef UTIL_AXIS_UART_RX_SYNC_EN
    logic [1:0] r_rx_sync;

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_rx_sync <= 2'b11;
        end else begin
            r_rx_sync <= {r_rx_sync[0], rx};
        end
    end

    assign w_rx = r_rx_sync[1];
`else
    assign w_rx = rx;
`endif

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [2:0]           r_rx_state;
    logic [c_CNT_W-1:0]   r_rx_cnt;
    logic [3:0]           r_rx_bit;
    logic [data_bits-1:0] r_rx_shift;
    logic                 r_rx_par_err;
    logic                 r_rx_prev;
    logic                 w_rx_bit_end;
    logic                 w_rx_done;
    logic [data_bits-1:0] r_m_tdata;
    logic                 r_m_tvalid;

    assign w_rx_bit_end = (r_rx_cnt == c_BIT_LAST);
    // Good frame: stop bit high and (when enabled) parity matched.
    assign w_rx_done    = (r_rx_state == c_RX_STOP) && w_rx_bit_end && w_rx &&
                          !(c_PAR_EN && r_rx_par_err);

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_rx_state   <= c_RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_err <= 1'b0;
            r_rx_prev    <= 1'b1;
        end else begin
            r_rx_prev <= w_rx;
            case (r_rx_state)
                c_RX_IDLE: begin
                    if (r_rx_prev && !w_rx) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= c_RX_START;
                    end
                end
                c_RX_START: begin
                    if (r_rx_cnt == c_RX_START_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        // High at mid-start means a glitch, not a frame.
                        r_rx_state <= w_rx ? c_RX_IDLE : c_RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                c_RX_DATA: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx, r_rx_shift[data_bits-1:1]};
                        if (r_rx_bit == c_DATA_LAST) begin
                            r_rx_bit   <= '0;
                            r_rx_state <= c_PAR_EN ? c_RX_PARITY : c_RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                c_RX_PARITY: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt     <= '0;
                        r_rx_par_err <= ((^r_rx_shift) ^ w_rx) != c_PAR_ODD;
                        r_rx_state   <= c_RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                c_RX_STOP: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= c_RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    r_rx_state <= c_RX_IDLE;
                end
            endcase
        end
    end

    // Output holding register: a completed frame is dropped while an
    // unconsumed byte is still held (overrun keeps the old byte).
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
        end else if (w_rx_done && (!r_m_tvalid || m_axis_tready)) begin
            r_m_tdata  <= r_rx_shift;
            r_m_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_util_axis_uart_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_util_axis_uart_sync
// Description : Directed bench for util_axis_uart_sync. Instance A: DIV=50,
//               8N1, rx_delay=10, tx loopable to rx. Instance B: DIV=8, even
//               parity, tx_delay=20, bench-driven rx. Instance C: DIV=8, odd
//               parity, tx only.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_util_axis_uart_sync;

    logic clk;
    logic arst;

    // Instance A
    logic [7:0] a_s_tdata;
    logic       a_s_tvalid;
    logic       a_s_tready;
    logic [7:0] a_m_tdata;
    logic       a_m_tvalid;
    logic       a_m_tready;
    logic       a_tx;
    logic       a_loop;
    logic       a_rx_drv;
    logic       a_rx;

    // Instance B
    logic [7:0] b_s_tdata;
    logic       b_s_tvalid;
    logic       b_s_tready;
    logic [7:0] b_m_tdata;
    logic       b_m_tvalid;
    logic       b_m_tready;
    logic       b_tx;
    logic       b_rx_drv;

    // Instance C
    logic [7:0] c_s_tdata;
    logic       c_s_tvalid;
    logic       c_s_tready;
    logic [7:0] c_m_tdata;
    logic       c_m_tvalid;
    logic       c_m_tready;
    logic       c_tx;
    logic       c_rx_drv;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] rxq[$];

    assign a_rx = a_loop ? a_tx : a_rx_drv;

    util_axis_uart_sync #(
        .baud_clock_speed(50000000), .baud_rate(1000000), .parity_ena(0),
        .parity_type(0), .stop_bits(1), .data_bits(8), .rx_delay(10), .tx_delay(0)
    ) u_dut_a (
        .aclk(clk), .arst(arst),
        .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
        .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
        .tx(a_tx), .rx(a_rx)
    );

    util_axis_uart_sync #(
        .baud_clock_speed(8000000), .baud_rate(1000000), .parity_ena(1),
        .parity_type(0), .stop_bits(1), .data_bits(8), .rx_delay(0), .tx_delay(20)
    ) u_dut_b (
        .aclk(clk), .arst(arst),
        .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
        .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
        .tx(b_tx), .rx(b_rx_drv)
    );

    util_axis_uart_sync #(
        .baud_clock_speed(8000000), .baud_rate(1000000), .parity_ena(1),
        .parity_type(1), .stop_bits(1), .data_bits(8), .rx_delay(0), .tx_delay(0)
    ) u_dut_c (
        .aclk(clk), .arst(arst),
        .s_axis_tdata(c_s_tdata), .s_axis_tvalid(c_s_tvalid), .s_axis_tready(c_s_tready),
        .m_axis_tdata(c_m_tdata), .m_axis_tvalid(c_m_tvalid), .m_axis_tready(c_m_tready),
        .tx(c_tx), .rx(c_rx_drv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every byte handed over on A's m_axis.
    always @(negedge clk) begin
        if (a_m_tvalid && a_m_tready) rxq.push_back(a_m_tdata);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int tgt, input logic v);
        if (tgt == 0) a_rx_drv = v;
        else b_rx_drv = v;
    endtask

    // Drive one serial frame: start, 8 data LSB first, optional parity, one stop.
    task automatic send_frame(input int tgt, input logic [7:0] d, input int div,
                              input logic par_en, input logic par, input logic stopv);
        set_rx(tgt, 1'b0);
        tick(div);
        for (int i = 0; i < 8; i++) begin
            set_rx(tgt, d[i]);
            tick(div);
        end
        if (par_en) begin
            set_rx(tgt, par);
            tick(div);
        end
        set_rx(tgt, stopv);
        tick(div);
        set_rx(tgt, 1'b1);
    endtask

    initial begin
        int n;
        int n0;

        arst = 1'b1;
        a_s_tdata = 8'h00; a_s_tvalid = 1'b0; a_m_tready = 1'b1; a_loop = 1'b1; a_rx_drv = 1'b1;
        b_s_tdata = 8'h00; b_s_tvalid = 1'b0; b_m_tready = 1'b0; b_rx_drv = 1'b1;
        c_s_tdata = 8'h00; c_s_tvalid = 1'b0; c_m_tready = 1'b1; c_rx_drv = 1'b1;
        tick(3);

        // ---------------- reset values ----------------
        chk("rst_tx", 32'(a_tx), 1);
        chk("rst_s_tready", 32'(a_s_tready), 0);
        chk("rst_m_tvalid", 32'(a_m_tvalid), 0);
        chk("rst_m_tdata", 32'(a_m_tdata), 0);
        arst = 1'b0;
        tick(1);
        chk("tready_after_release", 32'(a_s_tready), 1);

        // ---------------- A: first frame waveform ----------------
        a_s_tdata = 8'h41; a_s_tvalid = 1'b1;
        tick(1);                         // accept edge, k=0
        a_s_tdata = 8'h42;
        chk("tready_drop_on_accept", 32'(a_s_tready), 0);
        chk("tx_start_k0", 32'(a_tx), 0);
        tick(49);
        chk("tx_start_k49", 32'(a_tx), 0);
        tick(1);
        chk("tx_d0_k50", 32'(a_tx), 1);  // 0x41 bit0
        tick(50);
        chk("tx_d1_k100", 32'(a_tx), 0); // 0x41 bit1
        tick(350);
        chk("tx_stop_k450", 32'(a_tx), 1);
        tick(49);
        chk("tready_k499", 32'(a_s_tready), 0);
        tick(1);
        chk("tready_k500", 32'(a_s_tready), 1);

        // ---------------- A: loopback stream 0x42.. ----------------
        for (int i = 1; i < 20; i++) begin
            tick(1);                     // accept edge
            a_s_tdata = 8'(8'h41 + i + 1);
            n = 0;
            do begin
                tick(1);
                n++;
            end while (!a_s_tready && n < 1000);
            chk("accept_period", 32'(n), 500);
        end
        a_s_tvalid = 1'b0;
        tick(10);
        chk("loop_count", 32'(rxq.size()), 20);
        for (int i = 0; i < 20; i++) begin
            if (i < rxq.size()) chk("loop_byte", 32'(rxq[i]), 32'(8'h41 + i));
        end

        // ---------------- A: glitch rejection ----------------
        a_loop = 1'b0; a_rx_drv = 1'b1;
        tick(5);
        n0 = rxq.size();
        a_rx_drv = 1'b0;
        tick(10);
        a_rx_drv = 1'b1;
        tick(100);
        chk("glitch_no_byte", 32'(rxq.size()), 32'(n0));
        send_frame(0, 8'h55, 50, 1'b0, 1'b0, 1'b1);
        tick(5);
        chk("after_glitch_count", 32'(rxq.size()), 32'(n0 + 1));
        chk("after_glitch_byte", 32'(rxq[$]), 32'h55);

        // ---------------- A: overrun ----------------
        a_m_tready = 1'b0;
        send_frame(0, 8'hA5, 50, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'h5A, 50, 1'b0, 1'b0, 1'b1);
        tick(5);
        chk("ovr_tvalid", 32'(a_m_tvalid), 1);
        chk("ovr_tdata_held", 32'(a_m_tdata), 32'hA5);
        n0 = rxq.size();
        a_m_tready = 1'b1;
        tick(1);
        chk("ovr_consumed", 32'(a_m_tvalid), 0);
        tick(20);
        chk("ovr_second_dropped", 32'(a_m_tvalid), 0);
        chk("ovr_count", 32'(rxq.size()), 32'(n0 + 1));
        chk("ovr_byte", 32'(rxq[$]), 32'hA5);

        // ---------------- B/C: parity on tx, tx_delay ----------------
        b_s_tdata = 8'h07; b_s_tvalid = 1'b1;
        c_s_tdata = 8'h07; c_s_tvalid = 1'b1;
        tick(1);                         // both accept, k=0
        b_s_tvalid = 1'b0; c_s_tvalid = 1'b0;
        tick(76);                        // middle of parity bit
        chk("b_parity_even", 32'(b_tx), 1);
        chk("c_parity_odd", 32'(c_tx), 0);
        tick(8);                         // k=84, stop bit
        chk("b_stop", 32'(b_tx), 1);
        tick(23);                        // k=107
        chk("b_tready_gap", 32'(b_s_tready), 0);
        tick(1);                         // k=108 = stop end + 20
        chk("b_tready_rise", 32'(b_s_tready), 1);

        // ---------------- B: rx parity / framing ----------------
        send_frame(1, 8'h07, 8, 1'b1, 1'b1, 1'b1);
        tick(2);
        chk("b_rx_good_valid", 32'(b_m_tvalid), 1);
        chk("b_rx_good_data", 32'(b_m_tdata), 32'h07);
        b_m_tready = 1'b1;
        tick(1);
        b_m_tready = 1'b0;
        chk("b_rx_consumed", 32'(b_m_tvalid), 0);
        send_frame(1, 8'h07, 8, 1'b1, 1'b0, 1'b1);
        tick(2);
        chk("b_rx_bad_parity", 32'(b_m_tvalid), 0);
        send_frame(1, 8'h3C, 8, 1'b1, 1'b0, 1'b0);
        tick(2);
        chk("b_rx_bad_stop", 32'(b_m_tvalid), 0);
        send_frame(1, 8'h3C, 8, 1'b1, 1'b0, 1'b1);
        tick(2);
        chk("b_rx_recover_valid", 32'(b_m_tvalid), 1);
        chk("b_rx_recover_data", 32'(b_m_tdata), 32'h3C);

        // ---------------- A: reset mid-frame ----------------
        a_m_tready = 1'b0;
        send_frame(0, 8'h99, 50, 1'b0, 1'b0, 1'b1);
        tick(2);
        chk("pre_rst_held", 32'(a_m_tvalid), 1);
        a_loop = 1'b1;
        a_s_tdata = 8'hF0; a_s_tvalid = 1'b1;
        tick(1);
        a_s_tvalid = 1'b0;
        tick(120);                       // inside data bit 1
        n0 = rxq.size();
        arst = 1'b1;
        tick(1);
        chk("arst_tx", 32'(a_tx), 1);
        chk("arst_m_tvalid", 32'(a_m_tvalid), 0);
        chk("arst_m_tdata", 32'(a_m_tdata), 0);
        chk("arst_s_tready", 32'(a_s_tready), 0);
        arst = 1'b0;
        tick(1);
        chk("arst_release_tready", 32'(a_s_tready), 1);
        a_m_tready = 1'b1;
        tick(600);
        chk("arst_partial_discarded", 32'(rxq.size()), 32'(n0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
